// File: rtl/divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package divider_pkg;

    localparam int CLK_HZ_DEF      = 100_000_000;
    localparam int DEFAULT_HZ_DEF  = 1000;
    localparam int NUM_CH_DEF      = 4;
    localparam int CNT_W_DEF       = 27;

    // Half-period in clk cycles for a requested output frequency.
    function automatic int default_div(input int clk_hz, input int hz);
        return clk_hz / (2 * hz);
    endfunction

    // Width of a channel index; a single channel still needs one select bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_DIV_DEF = default_div(CLK_HZ_DEF, DEFAULT_HZ_DEF);
    localparam int CH_W_DEF        = ch_idx_w(NUM_CH_DEF);

    // A zero divisor would never wrap; treat it as the fastest rate, clk/2.
    function automatic logic [63:0] clamp_to_one(input logic [63:0] d);
        return (d == 64'd0) ? 64'd1 : d;
    endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: active/shadow divisor, half-period counter, square wave and rise tick.
module divider_channel
    import divider_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic             i_cfgEn,
    input  logic [CNT_W-1:0] i_cfgDiv,
    input  logic             i_sync,
    output logic             o_pending,
    output logic             o_clkout,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_en;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clkout;
    logic             r_tick;

    logic [CNT_W-1:0] w_newDiv;
    logic             w_wrap;

    assign w_newDiv  = CNT_W'(clamp_to_one(64'(i_cfgDiv)));
    assign w_wrap    = (r_cnt == (r_div - ONE));
    assign o_pending = r_pending;
    assign o_clkout  = r_clkout;
    assign o_tick    = r_tick;

    // Restart/direct-load events take priority over counting; a running channel only changes rate at a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= DIV_RST;
            r_shadow  <= DIV_RST;
            r_pending <= 1'b0;
            r_en      <= 1'b1;
            r_cnt     <= '0;
            r_clkout  <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_sync && i_wr) begin
            r_en      <= i_cfgEn;
            r_div     <= w_newDiv;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_clkout  <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_sync && r_en) begin
            if (r_pending) begin
                r_div <= r_shadow;
            end
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_clkout  <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_wr && (!i_cfgEn || !r_en)) begin
            r_en      <= i_cfgEn;
            r_div     <= w_newDiv;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_clkout  <= 1'b0;
            r_tick    <= 1'b0;
        end else if (r_en) begin
            if (i_wr) begin
                r_shadow  <= w_newDiv;
                r_pending <= 1'b1;
            end
            if (w_wrap) begin
                r_cnt    <= '0;
                r_clkout <= ~r_clkout;
                r_tick   <= ~r_clkout;
                if (r_pending) begin
                    r_div     <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + ONE;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_channel_clock_divider.sv
// Runtime-programmable multi-channel clock divider: config decode, ready mux and sync fan-out.
module multi_channel_clock_divider
    import divider_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_HZ  = DEFAULT_HZ_DEF,
    parameter int DEFAULT_DIV = default_div(CLK_HZ, DEFAULT_HZ),
    localparam int CH_W       = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_wr;
    logic              w_ready;

    // Ready reflects the addressed channel; an unmapped index is always ready and its write is dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_ready = !w_pending[i];
            end
        end
    end

    // One-hot write strobe for the channel whose handshake completes this cycle.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = cfg_valid && (cfg_ch == CH_W'(i)) && !w_pending[i];
        end
    end

    assign cfg_ready = w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        divider_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_wr     (w_wr[g]),
            .i_cfgEn  (cfg_en),
            .i_cfgDiv (cfg_div),
            .i_sync   (sync),
            .o_pending(w_pending[g]),
            .o_clkout (clkout[g]),
            .o_tick   (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Self-checking bench: time-based reference model of each channel plus directed literal checks.
module tb_multi_channel_clock_divider;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 27;
    localparam int CH_W    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic              cfg_en = 1'b0;
    logic              sync = 1'b0;
    logic [NUM_CH-1:0] clkout;
    logic [NUM_CH-1:0] tick;

    int assertCount = 0;
    int failCount   = 0;

    // Model state: each enabled channel is described by a restart time, a starting level and a divisor.
    int cyc;
    int mDiv[NUM_CH];
    int mShadow[NUM_CH];
    int mT0[NUM_CH];
    int mApply[NUM_CH];
    bit mEn[NUM_CH];
    bit mPend[NUM_CH];
    bit mL0[NUM_CH];
    bit mClk[NUM_CH];
    bit mTick[NUM_CH];

    multi_channel_clock_divider #(
        .CLK_HZ     (100_000_000),
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_HZ (1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .sync      (sync),
        .clkout    (clkout),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelInit();
        cyc = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            mDiv[ch]    = 50_000;
            mShadow[ch] = 50_000;
            mT0[ch]     = 0;
            mApply[ch]  = 0;
            mEn[ch]     = 1'b1;
            mPend[ch]   = 1'b0;
            mL0[ch]     = 1'b0;
            mClk[ch]    = 1'b0;
            mTick[ch]   = 1'b0;
        end
    endtask

    // Outputs after edge number cyc: level flips every mDiv cycles since the last restart.
    task automatic modelStep();
        int acc;
        int nd;
        int e;
        bit lvl;
        bit tk;
        acc = -1;
        if (cfg_valid && !mPend[cfg_ch]) acc = int'(cfg_ch);
        nd = (cfg_div == '0) ? 1 : int'(cfg_div);
        cyc++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            lvl = 1'b0;
            tk  = 1'b0;
            if (mEn[ch]) begin
                e   = cyc - mT0[ch];
                lvl = mL0[ch] ^ bit'((e / mDiv[ch]) % 2);
                tk  = (e > 0) && ((e % mDiv[ch]) == 0) && lvl;
                if (mPend[ch] && cyc == mApply[ch]) begin
                    mT0[ch]   = cyc;
                    mL0[ch]   = lvl;
                    mDiv[ch]  = mShadow[ch];
                    mPend[ch] = 1'b0;
                end
            end
            if (sync && acc == ch) begin
                mEn[ch]   = cfg_en;
                mDiv[ch]  = nd;
                mPend[ch] = 1'b0;
                mT0[ch]   = cyc;
                mL0[ch]   = 1'b0;
                lvl       = 1'b0;
                tk        = 1'b0;
            end else if (sync && mEn[ch]) begin
                if (mPend[ch]) mDiv[ch] = mShadow[ch];
                mPend[ch] = 1'b0;
                mT0[ch]   = cyc;
                mL0[ch]   = 1'b0;
                lvl       = 1'b0;
                tk        = 1'b0;
            end else if (acc == ch) begin
                if (!cfg_en) begin
                    mEn[ch]   = 1'b0;
                    mPend[ch] = 1'b0;
                    lvl       = 1'b0;
                    tk        = 1'b0;
                end else if (!mEn[ch]) begin
                    mEn[ch]  = 1'b1;
                    mDiv[ch] = nd;
                    mT0[ch]  = cyc;
                    mL0[ch]  = 1'b0;
                    lvl      = 1'b0;
                    tk       = 1'b0;
                end else begin
                    mShadow[ch] = nd;
                    mPend[ch]   = 1'b1;
                    e           = cyc - mT0[ch];
                    mApply[ch]  = mT0[ch] + mDiv[ch] * (e / mDiv[ch] + 1);
                end
            end
            mClk[ch]  = lvl;
            mTick[ch] = tk;
        end
    endtask

    // Model advances on every clock edge and re-initialises on reset assertion.
    initial begin
        modelInit();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelInit();
            else modelStep();
        end
    end

    // Compare every cycle on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checkOutput($sformatf("model clkout ch%0d", ch), 32'(clkout[ch]), 32'(mClk[ch]));
            checkOutput($sformatf("model tick ch%0d", ch), 32'(tick[ch]), 32'(mTick[ch]));
        end
        checkOutput("model cfg_ready", 32'(cfg_ready), 32'(!mPend[cfg_ch]));
    end

    // Single accepted config write; returns 2 time units after the accept edge.
    task automatic applyStimulus(input int ch, input int div, input bit en);
        @(posedge clk);
        #2;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(div);
        cfg_en    = en;
        @(posedge clk);
        #2;
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset clkout", 32'(clkout), 32'h0);
        checkOutput("reset tick", 32'(tick), 32'h0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;

        // Default 1 kHz: first rise on edge 50_000
        repeat (49_999) @(posedge clk);
        #1;
        checkOutput("default before rise", 32'(clkout), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("default first rise clkout", 32'(clkout), 32'hF);
        checkOutput("default first rise tick", 32'(tick), 32'hF);
        @(posedge clk);
        #1;
        checkOutput("default tick one cycle", 32'(tick), 32'h0);
        checkOutput("default clkout held", 32'(clkout), 32'hF);

        // Ch2 enabled from disabled with div 3
        applyStimulus(2, 0, 1'b0);
        applyStimulus(2, 3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ch2 low before rise", 32'(clkout[2]), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("ch2 rise at 3", 32'(clkout[2]), 32'h1);
        checkOutput("ch2 tick at 3", 32'(tick[2]), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("ch2 tick cleared", 32'(tick[2]), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ch2 tick period 6", 32'(tick[2]), 32'h1);

        // Ch0 at div 5, glitch-free update to 2 then a blocked second write of 4
        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 5, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = CNT_W'(2);
        cfg_en    = 1'b1;
        @(posedge clk);
        #2;
        cfg_div = CNT_W'(4);
        checkOutput("ch0 high at accept", 32'(clkout[0]), 32'h1);
        checkOutput("pending blocks ready", 32'(cfg_ready), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ch0 old half still high", 32'(clkout[0]), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("ch0 old half ends", 32'(clkout[0]), 32'h0);
        #1;
        checkOutput("ready after apply", 32'(cfg_ready), 32'h1);
        @(posedge clk);
        #2;
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ch0 rise after div2", 32'(clkout[0]), 32'h1);
        checkOutput("ch0 tick after div2", 32'(tick[0]), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ch0 div4 high", 32'(clkout[0]), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("ch0 div4 fall", 32'(clkout[0]), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("ch0 div4 rise", 32'(clkout[0]), 32'h1);
        checkOutput("ch0 div4 tick", 32'(tick[0]), 32'h1);

        // Ch1 with div 0 clamps to clk/2
        applyStimulus(1, 0, 1'b0);
        applyStimulus(1, 0, 1'b1);
        checkOutput("ch1 low after enable", 32'(clkout[1]), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("ch1 clk/2 high", 32'({clkout[1], tick[1]}), 32'h3);
        @(posedge clk);
        #1;
        checkOutput("ch1 clk/2 low", 32'({clkout[1], tick[1]}), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("ch1 clk/2 high again", 32'({clkout[1], tick[1]}), 32'h3);

        // Sync with ch2 at div 3 and ch3 at div 7
        applyStimulus(3, 0, 1'b0);
        applyStimulus(3, 7, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        sync = 1'b1;
        @(posedge clk);
        #2;
        sync = 1'b0;
        checkOutput("sync clears ch2/ch3", 32'(clkout[3:2]), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ch2 low before sync rise", 32'(clkout[2]), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("ch2 sync rise", 32'({clkout[2], tick[2]}), 32'h3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ch3 low before sync rise", 32'(clkout[3]), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("ch3 sync rise", 32'({clkout[3], tick[3]}), 32'h3);

        // Randomised writes and syncs against the model
        repeat (3000) begin
            @(posedge clk);
            #2;
            cfg_valid = ($urandom_range(0, 4) == 0);
            cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            cfg_div   = CNT_W'($urandom_range(0, 9));
            cfg_en    = ($urandom_range(0, 7) != 0);
            sync      = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk);
        #2;
        cfg_valid = 1'b0;
        sync      = 1'b0;

        // Asynchronous reset mid half-period
        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset clkout", 32'(clkout), 32'h0);
        checkOutput("async reset tick", 32'(tick), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset right after a write goes pending
        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 3, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = CNT_W'(9);
        cfg_en    = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        checkOutput("reset at write clkout", 32'(clkout), 32'h0);
        checkOutput("reset at write tick", 32'(tick), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cfg_ch = 2'd0;
        #1;
        checkOutput("no pending after reset", 32'(cfg_ready), 32'h1);
        repeat (200) @(posedge clk);
        #1;
        checkOutput("default rate after reset", 32'(clkout), 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
